// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq -- sequential integer matrix multiplier, R = A x B.
//
// One multiply-accumulate per clock. A start pulse in IDLE latches both
// operand matrices; the run then walks i (rows of A), j (columns of B) and
// k (inner dimension), finishing one R element every A_COLS cycles. When
// the last element is written, one extra cycle copies the working matrix
// to the result register and pulses done.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     request a run (sampled only when idle)
//   a_in      A, row-major, A(0,0) in the MSBs
//   b_in      B, row-major, B(0,0) in the MSBs
//   busy      run in progress
//   done      one-cycle pulse, res valid from this cycle on
//   res       R, row-major, R(0,0) in the MSBs, low RES_W bits of each sum
//   overflow  some element of the last completed run did not fit in RES_W
module matrix_mult_seq #(
  parameter int A_ROWS = 3,
  parameter int A_COLS = 2,
  parameter int B_COLS = 3,
  parameter int ELEM_W = 8,
  parameter int RES_W  = 18,
  parameter bit SIGNED = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [A_ROWS*A_COLS*ELEM_W-1:0] a_in,
  input  logic [A_COLS*B_COLS*ELEM_W-1:0] b_in,
  output logic                            busy,
  output logic                            done,
  output logic [A_ROWS*B_COLS*RES_W-1:0]  res,
  output logic                            overflow
);
  localparam int NA    = A_ROWS * A_COLS;
  localparam int NB    = A_COLS * B_COLS;
  localparam int NR    = A_ROWS * B_COLS;
  // Wide enough that the sum of A_COLS full products can never wrap.
  localparam int ACC_W = 2 * ELEM_W + $clog2(A_COLS) + 1;
  localparam int EXT_W = (ACC_W > RES_W) ? ACC_W : RES_W;
  localparam int IW    = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
  localparam int JW    = (B_COLS > 1) ? $clog2(B_COLS) : 1;
  localparam int KW    = (A_COLS > 1) ? $clog2(A_COLS) : 1;
  localparam int AIW   = (NA > 1) ? $clog2(NA) : 1;
  localparam int BIW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int RIW   = (NR > 1) ? $clog2(NR) : 1;
  // All bits from the RES_W-1 sign position upward set (signed fit test).
  localparam logic [EXT_W-1:0] UPPER_ONES = {EXT_W{1'b1}} >> (RES_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [NA*ELEM_W-1:0]  r_a;
  logic [NB*ELEM_W-1:0]  r_b;
  logic [IW-1:0]         r_i;
  logic [JW-1:0]         r_j;
  logic [KW-1:0]         r_k;
  logic [ACC_W-1:0]      r_acc;
  logic [RES_W-1:0]      r_work [NR];
  logic                  r_ovf_work;
  logic [NR*RES_W-1:0]   r_res;
  logic                  r_overflow;
  logic                  r_done;

  logic [ELEM_W-1:0]     w_a_arr [NA];
  logic [ELEM_W-1:0]     w_b_arr [NB];
  logic [NR*RES_W-1:0]   w_work_flat;
  logic [AIW-1:0]        w_a_idx;
  logic [BIW-1:0]        w_b_idx;
  logic [RIW-1:0]        w_r_idx;
  logic                  w_i_last;
  logic                  w_j_last;
  logic                  w_k_last;
  logic [ELEM_W-1:0]     w_a_elem;
  logic [ELEM_W-1:0]     w_b_elem;
  logic [ACC_W-1:0]      w_a_ext;
  logic [ACC_W-1:0]      w_b_ext;
  logic [ACC_W-1:0]      w_prod;
  logic [ACC_W-1:0]      w_sum;
  logic [EXT_W-1:0]      w_sum_ext;
  logic [EXT_W-1:0]      w_upper;
  logic                  w_elem_ovf;

  // Unpack the latched operands and pack the working matrix; element 0
  // lives in the most significant slice.
  genvar gi;
  generate
    for (gi = 0; gi < NA; gi++) begin : g_a_unpack
      assign w_a_arr[gi] = r_a[(NA-1-gi)*ELEM_W +: ELEM_W];
    end
    for (gi = 0; gi < NB; gi++) begin : g_b_unpack
      assign w_b_arr[gi] = r_b[(NB-1-gi)*ELEM_W +: ELEM_W];
    end
    for (gi = 0; gi < NR; gi++) begin : g_work_pack
      assign w_work_flat[(NR-1-gi)*RES_W +: RES_W] = r_work[gi];
    end
  endgenerate

  // MAC datapath: product of A(i,k) and B(k,j), extended to the accumulator
  // width so a single ACC_W-bit multiply gives the exact result.
  always_comb begin
    w_a_idx  = AIW'(r_i * A_COLS + r_k);
    w_b_idx  = BIW'(r_k * B_COLS + r_j);
    w_r_idx  = RIW'(r_i * B_COLS + r_j);
    w_i_last = (r_i == IW'(A_ROWS - 1));
    w_j_last = (r_j == JW'(B_COLS - 1));
    w_k_last = (r_k == KW'(A_COLS - 1));
    w_a_elem = w_a_arr[w_a_idx];
    w_b_elem = w_b_arr[w_b_idx];
    if (SIGNED) begin
      w_a_ext = ACC_W'(signed'(w_a_elem));
      w_b_ext = ACC_W'(signed'(w_b_elem));
    end else begin
      w_a_ext = ACC_W'(w_a_elem);
      w_b_ext = ACC_W'(w_b_elem);
    end
    w_prod = w_a_ext * w_b_ext;
    w_sum  = r_acc + w_prod;
    if (SIGNED) begin
      w_sum_ext = EXT_W'(signed'(w_sum));
    end else begin
      w_sum_ext = EXT_W'(w_sum);
    end
    // Signed fit: everything from bit RES_W-1 up must be a pure sign run.
    w_upper = w_sum_ext >> (RES_W - 1);
    if (SIGNED) begin
      w_elem_ovf = (w_upper != '0) && (w_upper != UPPER_ONES);
    end else begin
      w_elem_ovf = (w_sum_ext >> RES_W) != '0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_MAC;
      S_MAC:   if (w_k_last && w_j_last && w_i_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = r_done;
    res      = r_res;
    overflow = r_overflow;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_ovf_work <= 1'b0;
      r_res      <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      for (int n = 0; n < NR; n++) r_work[n] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a        <= a_in;
            r_b        <= b_in;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_ovf_work <= 1'b0;
          end
        end
        S_MAC: begin
          if (w_k_last) begin
            r_work[w_r_idx] <= w_sum_ext[RES_W-1:0];
            r_ovf_work      <= r_ovf_work | w_elem_ovf;
            r_acc           <= '0;
            r_k             <= '0;
            if (w_j_last) begin
              r_j <= '0;
              r_i <= w_i_last ? '0 : r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_acc <= w_sum;
            r_k   <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          r_res      <= w_work_flat;
          r_overflow <= r_ovf_work;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_mult_seq.sv
// Bench for matrix_mult_seq. Three instances share clk/rst/start/operands:
// the default configuration, RES_W=16 (overflow case) and SIGNED=1. Each
// result is compared against a plain-integer reference model.
module tb_matrix_mult_seq;
  localparam int AR = 3;
  localparam int AC = 2;
  localparam int BC = 3;
  localparam int N  = AR * BC * AC;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [47:0]  a_in = '0;
  logic [47:0]  b_in = '0;
  logic         busy0, busy1, busy2;
  logic         done0, done1, done2;
  logic         ovf0, ovf1, ovf2;
  logic [161:0] res0;
  logic [143:0] res1;
  logic [161:0] res2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_mult_seq dut0 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy0), .done(done0), .res(res0), .overflow(ovf0)
  );
  matrix_mult_seq #(.RES_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy1), .done(done1), .res(res1), .overflow(ovf1)
  );
  matrix_mult_seq #(.SIGNED(1'b1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy2), .done(done2), .res(res2), .overflow(ovf2)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Element idx (row-major) of a packed 6-element byte matrix.
  function automatic longint elem(input logic [47:0] m, input int idx, input bit sgn);
    longint v;
    v = longint'((m >> ((5 - idx) * 8)) & 48'hFF);
    if (sgn && v >= 128) v = v - 256;
    return v;
  endfunction

  // Reference: exact integer matrix product, then wrap to rw bits.
  task automatic model(input logic [47:0] a, input logic [47:0] b, input int rw,
                       input bit sgn, output logic [255:0] r, output bit ovf);
    longint s, one, lo, hi, low;
    one = 1;
    r   = '0;
    ovf = 1'b0;
    lo  = -(one << (rw - 1));
    hi  = (one << (rw - 1)) - 1;
    for (int i = 0; i < AR; i++) begin
      for (int j = 0; j < BC; j++) begin
        s = 0;
        for (int k = 0; k < AC; k++) s += elem(a, i*AC + k, sgn) * elem(b, k*BC + j, sgn);
        if (sgn) ovf |= (s < lo) || (s > hi);
        else     ovf |= (s >= (one << rw));
        low = s & ((one << rw) - 1);
        r = r | (256'(low) << ((AR*BC - 1 - (i*BC + j)) * rw));
      end
    end
  endtask

  task automatic check_results(input string tag, input logic [47:0] a, input logic [47:0] b);
    logic [255:0] e0, e1, e2;
    bit o0, o1, o2;
    model(a, b, 18, 1'b0, e0, o0);
    model(a, b, 16, 1'b0, e1, o1);
    model(a, b, 18, 1'b1, e2, o2);
    chk({tag, "_res0"}, 256'(res0), e0);
    chk({tag, "_res1"}, 256'(res1), e1);
    chk({tag, "_res2"}, 256'(res2), e2);
    chk({tag, "_ovf"}, {253'd0, ovf0, ovf1, ovf2}, {253'd0, o0, o1, o2});
  endtask

  // Full run: start pulsed at E0, checks latency, busy, hold of res, done width.
  task automatic run_op(input string tag, input logic [47:0] a, input logic [47:0] b);
    logic [161:0] hold;
    bit hold_ok, busy_ok;
    int c;
    hold  = res0;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    c       = 0;
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    while (done0 !== 1'b1 && c < 100) begin
      if (res0 !== hold) hold_ok = 1'b0;
      if (busy0 !== 1'b1 || busy1 !== 1'b1 || busy2 !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      c++;
    end
    chk({tag, "_latency"}, 256'(c), 256'(N + 1));
    chk({tag, "_busy_run"}, 256'(busy_ok), 256'(1));
    chk({tag, "_res_hold"}, 256'(hold_ok), 256'(1));
    chk({tag, "_done_busy"}, {252'd0, busy0, done1, done2, busy2}, {252'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    check_results(tag, a, b);
    @(negedge clk);
    chk({tag, "_done_width"}, {254'd0, done0, busy0}, 256'd0);
    $display("run %s a=%h b=%h res0=%h ovf=%b%b%b", tag, a, b, res0, ovf0, ovf1, ovf2);
  endtask

  initial begin
    logic [47:0] ones, twos, ff;
    logic [47:0] ra, rb;
    logic [161:0] prev, cap;
    logic [255:0] e0;
    bit o0, bad_done, stable;
    int ndone, nbad, c;
    int dpos [$];
    ones = {6{8'd1}};
    twos = {6{8'd2}};
    ff   = {6{8'hFF}};

    // Reset with start held high: reset wins, nothing starts.
    start = 1'b1;
    a_in  = ones;
    b_in  = ones;
    repeat (3) @(negedge clk);
    chk("reset_state", {64'd0, res0, busy0, done0, ovf0},
        256'd0);
    chk("reset_others", {250'd0, busy1, busy2, done1, done2, ovf1, ovf2}, 256'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 256'(busy0), 256'd0);
    $display("reset checked");

    // Scenario 1: all elements 3.
    run_op("t1", {8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2}, ones);
    chk("t1_elem00", 256'(res0[161:144]), 256'd3);

    // Scenario 2: overflow in RES_W=16, then a clean run clears it.
    run_op("t2a", ff, ff);
    chk("t2a_elem", 256'(res1[143:128]), 256'd64514);
    chk("t2a_ovf1", 256'(ovf1), 256'd1);
    run_op("t2b", ones, ones);
    chk("t2b_ovf1", 256'(ovf1), 256'd0);

    // Scenario 3: signed -1 * 2 summed twice.
    run_op("t3", ff, twos);
    chk("t3_elem", 256'(res2[17:0]), 256'h3FFFC);

    // Scenario 4: reset at E5 aborts the run.
    a_in  = {8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
    b_in  = ones;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_abort", {64'd0, res0, busy0, done0, ovf0}, 256'd0);
    bad_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done0 !== 1'b0) bad_done = 1'b1;
    end
    chk("t4_no_done", 256'(bad_done), 256'd0);
    $display("reset mid-run checked");
    run_op("t4r", {8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2}, ones);

    // Scenario 5: operand isolation; a_in zeroed and start re-pulsed mid-run.
    ra   = 48'h0A_14_1E_28_32_3C;
    rb   = 48'h03_05_07_0B_0D_11;
    prev = res0;
    model(ra, rb, 18, 1'b0, e0, o0);
    a_in  = ra;
    b_in  = rb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a_in  = '0;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    ndone  = 0;
    stable = 1'b1;
    cap    = '0;
    repeat (40) begin
      if (done0 === 1'b1) begin
        if (ndone == 0) cap = res0;
        ndone++;
      end else if (ndone == 0 && res0 !== prev) begin
        stable = 1'b0;
      end
      @(negedge clk);
    end
    chk("t5_done_count", 256'(ndone), 256'd1);
    chk("t5_hold", 256'(stable), 256'd1);
    chk("t5_res", 256'(cap), e0);
    $display("isolation checked dones=%0d res=%h", ndone, cap);

    // Scenario 6: start held high, done every N+2 cycles.
    a_in  = ones;
    b_in  = twos;
    start = 1'b1;
    nbad  = 0;
    for (int t = 0; t < 65; t++) begin
      @(negedge clk);
      if (done0 === 1'b1) dpos.push_back(t);
      if (busy0 === done0) nbad++;
    end
    chk("t6_done_count", 256'(dpos.size()), 256'd3);
    if (dpos.size() == 3) begin
      chk("t6_first", 256'(dpos[0]), 256'(N + 1));
      chk("t6_period1", 256'(dpos[1] - dpos[0]), 256'(N + 2));
      chk("t6_period2", 256'(dpos[2] - dpos[1]), 256'(N + 2));
    end
    chk("t6_busy_gap", 256'(nbad), 256'd0);
    start = 1'b0;
    c = 0;
    while (done0 !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("t6_drain", 256'(done0), 256'd1);
    check_results("t6", ones, twos);
    @(negedge clk);
    $display("back-to-back checked dones=%0d", dpos.size());

    // Randomized runs against the model.
    for (int r = 0; r < 6; r++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_op($sformatf("rnd%0d", r), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
